// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the synchronous programmable FIFO:
//   - clog2()      : ceiling log2, used for pointer and count widths
//   - DEF_WIDTH    : default data word width
//   - DEF_DEPTH    : default word capacity
//   - fifo_mode_e  : read-side mode encoding (standard / first-word-fall-through)
// -----------------------------------------------------------------------------
package fifo_pkg;

  localparam int DEF_WIDTH = 9;
  localparam int DEF_DEPTH = 16;

  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_ram_sdp.sv
// -----------------------------------------------------------------------------
// fifo_ram_sdp
// Simple dual-port storage: one write port, one read port with a registered
// output. No reset on the array or the read register so it maps onto block RAM.
// Ports:
//   clk_i    : clock, rising edge
//   we_i     : write enable
//   waddr_i  : write address
//   wdata_i  : write data
//   re_i     : read enable (rdata_o updates on the next edge only when set)
//   raddr_i  : read address
//   rdata_o  : registered read data, holds when re_i is low
// -----------------------------------------------------------------------------
module fifo_ram_sdp
  import fifo_pkg::*;
#(
  parameter int Width     = DEF_WIDTH,
  parameter int Depth     = DEF_DEPTH,
  parameter int AddrWidth = clog2(Depth)
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic [AddrWidth-1:0] waddr_i,
  input  logic [Width-1:0]     wdata_i,
  input  logic                 re_i,
  input  logic [AddrWidth-1:0] raddr_i,
  output logic [Width-1:0]     rdata_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fifo_sync_prog.sv
// -----------------------------------------------------------------------------
// fifo_sync_prog
// Single-clock FIFO with runtime-programmable full/empty thresholds, optional
// first-word-fall-through output, sticky overflow/underflow and write ack.
// Ports:
//   Clk, ResetN          : clock (rising edge), async active-low reset
//   Clear                : synchronous flush, overrides Write/Read
//   Write, Din           : write request and data
//   Read                 : read request (pop in FWFT mode)
//   ProgFullThresh       : ProgFull asserts when DataCount >= this
//   ProgEmptyThresh      : ProgEmpty asserts when DataCount <= this
//   Dout, Valid          : read data and its qualifier
//   Full, Empty, AlmostFull, AlmostEmpty, ProgFull, ProgEmpty : status
//   DataCount            : words held, including the FWFT output word
//   WrAck                : one-cycle acknowledge of an accepted write
//   Overflow, Underflow  : sticky error flags, cleared by reset or Clear
// -----------------------------------------------------------------------------
module fifo_sync_prog
  import fifo_pkg::*;
#(
  parameter int Width         = DEF_WIDTH,
  parameter int Depth         = DEF_DEPTH,
  parameter int FirstWordFall = 0,
  parameter int CountWidth    = clog2(Depth) + 1
) (
  input  logic                  Clk,
  input  logic                  ResetN,
  input  logic                  Clear,
  input  logic                  Write,
  input  logic [Width-1:0]      Din,
  input  logic                  Read,
  input  logic [CountWidth-1:0] ProgFullThresh,
  input  logic [CountWidth-1:0] ProgEmptyThresh,
  output logic [Width-1:0]      Dout,
  output logic                  Valid,
  output logic                  Full,
  output logic                  Empty,
  output logic                  AlmostFull,
  output logic                  AlmostEmpty,
  output logic                  ProgFull,
  output logic                  ProgEmpty,
  output logic [CountWidth-1:0] DataCount,
  output logic                  WrAck,
  output logic                  Overflow,
  output logic                  Underflow
);

  localparam int AddrWidth = clog2(Depth);
  localparam fifo_mode_e Mode = (FirstWordFall != 0) ? FIFO_FWFT : FIFO_STD;
  localparam logic [CountWidth-1:0] CntDepth = CountWidth'(Depth);
  localparam logic [CountWidth-1:0] CntDepthM1 = CountWidth'(Depth - 1);
  localparam logic [CountWidth-1:0] CntOne = CountWidth'(1);

  logic [1:0]            rst_sync_q;
  logic                  run;
  logic [AddrWidth-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CountWidth-1:0] ram_cnt_q, ram_cnt_d, count_q, count_d;
  logic                  ram_avail_q, ram_avail_d;
  logic                  valid_q, valid_d;
  logic                  dout_ok_q, dout_ok_d;
  logic                  wrack_q, wrack_d, ovf_q, ovf_d, udf_q, udf_d;
  logic                  full_q, afull_q, aempty_q, pfull_q, pempty_q;
  logic                  empty_now, wr_ok, pop, rd_fetch, rd_acc;
  logic [Width-1:0]      rd_data;

  // Deassertion of ResetN is only seen by the datapath after two edges.
  assign run = rst_sync_q[1];

  // Standard mode is empty until the RAM holds a word that is readable;
  // FWFT mode is empty whenever the output word is not present.
  assign empty_now = (Mode == FIFO_FWFT) ? ~valid_q : ~ram_avail_q;

  always_comb begin
    wr_ok    = Write & ~full_q & ~Clear & run;
    pop      = 1'b0;
    rd_fetch = 1'b0;
    rd_acc   = 1'b0;
    if (Mode == FIFO_FWFT) begin
      pop      = Read & valid_q & ~Clear & run;
      // Refill the output word whenever it is empty or being popped.
      rd_fetch = ram_avail_q & (~valid_q | pop) & ~Clear & run;
      rd_acc   = pop;
    end else begin
      rd_fetch = Read & ram_avail_q & ~Clear & run;
      rd_acc   = rd_fetch;
    end

    wr_ptr_d  = wr_ptr_q + AddrWidth'(wr_ok);
    rd_ptr_d  = rd_ptr_q + AddrWidth'(rd_fetch);
    ram_cnt_d = ram_cnt_q + CountWidth'(wr_ok) - CountWidth'(rd_fetch);
    count_d   = count_q + CountWidth'(wr_ok) - CountWidth'(rd_acc);
    valid_d   = (Mode == FIFO_FWFT) ? (rd_fetch | (valid_q & ~pop)) : rd_fetch;
    dout_ok_d = dout_ok_q | rd_fetch;
    wrack_d   = wr_ok;
    ovf_d     = ovf_q | (Write & full_q & ~Clear & run);
    udf_d     = udf_q | (Read & empty_now & ~Clear & run);

    if (Clear) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      ram_cnt_d = '0;
      count_d   = '0;
      valid_d   = 1'b0;
      ovf_d     = 1'b0;
      udf_d     = 1'b0;
    end

    // A word becomes readable one edge after it was written, so the read
    // port never addresses a location that is being written on the same edge.
    ram_avail_d = (ram_cnt_d != '0) & (ram_cnt_q != '0);
  end

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      rst_sync_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ram_cnt_q   <= '0;
      count_q     <= '0;
      ram_avail_q <= 1'b0;
      valid_q     <= 1'b0;
      dout_ok_q   <= 1'b0;
      wrack_q     <= 1'b0;
      ovf_q       <= 1'b0;
      udf_q       <= 1'b0;
      full_q      <= 1'b0;
      afull_q     <= 1'b0;
      aempty_q    <= 1'b1;
      pfull_q     <= 1'b0;
      pempty_q    <= 1'b1;
    end else begin
      rst_sync_q  <= {rst_sync_q[0], 1'b1};
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ram_cnt_q   <= ram_cnt_d;
      count_q     <= count_d;
      ram_avail_q <= ram_avail_d;
      valid_q     <= valid_d;
      dout_ok_q   <= dout_ok_d;
      wrack_q     <= wrack_d;
      ovf_q       <= ovf_d;
      udf_q       <= udf_d;
      full_q      <= (count_d == CntDepth);
      afull_q     <= (count_d >= CntDepthM1);
      aempty_q    <= (count_d <= CntOne);
      pfull_q     <= (count_d >= ProgFullThresh);
      pempty_q    <= (count_d <= ProgEmptyThresh);
    end
  end

  fifo_ram_sdp #(
    .Width    (Width),
    .Depth    (Depth),
    .AddrWidth(AddrWidth)
  ) u_ram (
    .clk_i  (Clk),
    .we_i   (wr_ok),
    .waddr_i(wr_ptr_q),
    .wdata_i(Din),
    .re_i   (rd_fetch),
    .raddr_i(rd_ptr_q),
    .rdata_o(rd_data)
  );

  // The RAM read register has no reset; mask it until a word has been read
  // since reset so stale contents never reach Dout.
  assign Dout        = dout_ok_q ? rd_data : '0;
  assign Valid       = valid_q;
  assign Empty       = empty_now;
  assign Full        = full_q;
  assign AlmostFull  = afull_q;
  assign AlmostEmpty = aempty_q;
  assign ProgFull    = pfull_q;
  assign ProgEmpty   = pempty_q;
  assign DataCount   = count_q;
  assign WrAck       = wrack_q;
  assign Overflow    = ovf_q;
  assign Underflow   = udf_q;

endmodule

// File: tb/tb_fifo_sync_prog.sv
// -----------------------------------------------------------------------------
// tb_fifo_sync_prog
// Directed bench for fifo_sync_prog: one standard-mode and one FWFT instance,
// Depth=16, Width=9, ProgFullThresh=12, ProgEmptyThresh=5.
// -----------------------------------------------------------------------------
module tb_fifo_sync_prog;

  localparam int W  = 9;
  localparam int D  = 16;
  localparam int CW = 5;

  logic Clk = 1'b0;
  logic ResetN;
  logic [CW-1:0] pf_th, pe_th;

  always #5 Clk = ~Clk;

  logic          s_clr, s_wr, s_rd;
  logic [W-1:0]  s_din, s_dout;
  logic          s_valid, s_full, s_empty, s_af, s_ae, s_pf, s_pe;
  logic          s_wrack, s_ovf, s_udf;
  logic [CW-1:0] s_cnt;

  logic          f_clr, f_wr, f_rd;
  logic [W-1:0]  f_din, f_dout;
  logic          f_valid, f_full, f_empty, f_af, f_ae, f_pf, f_pe;
  logic          f_wrack, f_ovf, f_udf;
  logic [CW-1:0] f_cnt;

  int n_run  = 0;
  int n_fail = 0;

  fifo_sync_prog #(.Width(W), .Depth(D), .FirstWordFall(0), .CountWidth(CW)) u_std (
    .Clk(Clk), .ResetN(ResetN), .Clear(s_clr), .Write(s_wr), .Din(s_din), .Read(s_rd),
    .ProgFullThresh(pf_th), .ProgEmptyThresh(pe_th), .Dout(s_dout), .Valid(s_valid),
    .Full(s_full), .Empty(s_empty), .AlmostFull(s_af), .AlmostEmpty(s_ae),
    .ProgFull(s_pf), .ProgEmpty(s_pe), .DataCount(s_cnt), .WrAck(s_wrack),
    .Overflow(s_ovf), .Underflow(s_udf)
  );

  fifo_sync_prog #(.Width(W), .Depth(D), .FirstWordFall(1), .CountWidth(CW)) u_fwft (
    .Clk(Clk), .ResetN(ResetN), .Clear(f_clr), .Write(f_wr), .Din(f_din), .Read(f_rd),
    .ProgFullThresh(pf_th), .ProgEmptyThresh(pe_th), .Dout(f_dout), .Valid(f_valid),
    .Full(f_full), .Empty(f_empty), .AlmostFull(f_af), .AlmostEmpty(f_ae),
    .ProgFull(f_pf), .ProgEmpty(f_pe), .DataCount(f_cnt), .WrAck(f_wrack),
    .Overflow(f_ovf), .Underflow(f_udf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk_rst();
    check("rst_dout",   32'(s_dout),  32'h0);
    check("rst_valid",  32'(s_valid), 32'h0);
    check("rst_cnt",    32'(s_cnt),   32'h0);
    check("rst_empty",  32'(s_empty), 32'h1);
    check("rst_aempty", 32'(s_ae),    32'h1);
    check("rst_pempty", 32'(s_pe),    32'h1);
    check("rst_full",   32'(s_full),  32'h0);
    check("rst_afull",  32'(s_af),    32'h0);
    check("rst_pfull",  32'(s_pf),    32'h0);
    check("rst_wrack",  32'(s_wrack), 32'h0);
    check("rst_ovf",    32'(s_ovf),   32'h0);
    check("rst_udf",    32'(s_udf),   32'h0);
    check("rst_f_valid", 32'(f_valid), 32'h0);
    check("rst_f_empty", 32'(f_empty), 32'h1);
    check("rst_f_dout",  32'(f_dout),  32'h0);
  endtask

  initial begin
    ResetN = 1'b0;
    s_clr = 0; s_wr = 0; s_rd = 0; s_din = '0;
    f_clr = 0; f_wr = 0; f_rd = 0; f_din = '0;
    pf_th = 5'd12;
    pe_th = 5'd5;
    #12;
    chk_rst();

    // Release reset; a write on the first edge afterwards must be ignored.
    @(posedge Clk); #1;
    ResetN = 1'b1;
    s_wr = 1; s_din = 9'h0EE;
    step();
    s_wr = 0;
    check("sync_ignore_cnt", 32'(s_cnt), 32'h0);
    step(); step();

    // Fill 0x001..0x010 with status flags at every count.
    for (int i = 1; i <= 16; i++) begin
      s_wr = 1; s_din = W'(i);
      step();
      check("fill_cnt",    32'(s_cnt),   32'(i));
      check("fill_wrack",  32'(s_wrack), 32'h1);
      check("fill_empty",  32'(s_empty), 32'(i == 1));
      check("fill_full",   32'(s_full),  32'(i == 16));
      check("fill_afull",  32'(s_af),    32'(i >= 15));
      check("fill_aempty", 32'(s_ae),    32'(i <= 1));
      check("fill_pfull",  32'(s_pf),    32'(i >= 12));
      check("fill_pempty", 32'(s_pe),    32'(i <= 5));
    end

    // Write while full, with a simultaneous read: write dropped, read taken.
    s_wr = 1; s_din = 9'h011; s_rd = 1;
    step();
    s_wr = 0;
    check("ovf_set",     32'(s_ovf),   32'h1);
    check("ovf_wrack",   32'(s_wrack), 32'h0);
    check("ovf_cnt",     32'(s_cnt),   32'd15);
    check("rd1_dout",    32'(s_dout),  32'h001);
    check("rd1_valid",   32'(s_valid), 32'h1);

    for (int i = 2; i <= 16; i++) begin
      step();
      check("drain_dout",  32'(s_dout),  32'(i));
      check("drain_valid", 32'(s_valid), 32'h1);
      check("drain_cnt",   32'(s_cnt),   32'(16 - i));
    end
    check("drain_empty", 32'(s_empty), 32'h1);
    s_rd = 0;
    step();
    check("idle_valid", 32'(s_valid), 32'h0);
    check("idle_hold",  32'(s_dout),  32'h010);

    s_rd = 1;
    step();
    s_rd = 0;
    check("udf_set",   32'(s_udf),   32'h1);
    check("udf_valid", 32'(s_valid), 32'h0);
    check("udf_cnt",   32'(s_cnt),   32'h0);
    check("ovf_hold",  32'(s_ovf),   32'h1);

    // Clear beats a concurrent write and drops the sticky flags.
    for (int i = 0; i < 3; i++) begin
      s_wr = 1; s_din = W'(9'h0A0 + i);
      step();
    end
    check("pre_clr_cnt", 32'(s_cnt), 32'd3);
    s_clr = 1; s_din = 9'h0FF;
    step();
    s_clr = 0; s_wr = 0;
    check("clr_cnt",    32'(s_cnt),   32'h0);
    check("clr_empty",  32'(s_empty), 32'h1);
    check("clr_pempty", 32'(s_pe),    32'h1);
    check("clr_ovf",    32'(s_ovf),   32'h0);
    check("clr_udf",    32'(s_udf),   32'h0);
    check("clr_wrack",  32'(s_wrack), 32'h0);
    step();

    // Steady-state streaming at count 8 across pointer wrap.
    for (int i = 0; i < 8; i++) begin
      s_wr = 1; s_din = W'(9'h100 + i);
      step();
    end
    check("wrap_pre_cnt", 32'(s_cnt), 32'd8);
    s_rd = 1;
    for (int j = 0; j < 40; j++) begin
      s_din = W'(9'h108 + j);
      step();
      check("wrap_dout",  32'(s_dout),  32'(9'h100 + j));
      check("wrap_valid", 32'(s_valid), 32'h1);
      check("wrap_cnt",   32'(s_cnt),   32'd8);
    end
    s_wr = 0;
    for (int j = 40; j < 48; j++) begin
      step();
      check("wrap_tail", 32'(s_dout), 32'(9'h100 + j));
    end
    s_rd = 0;
    check("wrap_end_cnt",   32'(s_cnt),   32'h0);
    check("wrap_end_empty", 32'(s_empty), 32'h1);

    // FWFT: single word presented two edges after its write.
    f_wr = 1; f_din = 9'h155;
    step();
    f_wr = 0;
    check("fw_k_valid", 32'(f_valid), 32'h0);
    check("fw_k_cnt",   32'(f_cnt),   32'd1);
    step();
    check("fw_k1_valid", 32'(f_valid), 32'h0);
    step();
    check("fw_k2_valid", 32'(f_valid), 32'h1);
    check("fw_k2_dout",  32'(f_dout),  32'h155);
    check("fw_k2_cnt",   32'(f_cnt),   32'd1);
    check("fw_k2_empty", 32'(f_empty), 32'h0);
    f_rd = 1;
    step();
    f_rd = 0;
    check("fw_pop_valid", 32'(f_valid), 32'h0);
    check("fw_pop_empty", 32'(f_empty), 32'h1);
    check("fw_pop_cnt",   32'(f_cnt),   32'h0);

    // FWFT: back-to-back pops present the next word each cycle.
    for (int i = 0; i < 3; i++) begin
      f_wr = 1; f_din = W'(9'h0A1 + i);
      step();
    end
    f_wr = 0;
    step(); step();
    check("fw3_head", 32'(f_dout), 32'h0A1);
    check("fw3_cnt",  32'(f_cnt),  32'd3);
    f_rd = 1;
    for (int i = 1; i < 3; i++) begin
      step();
      check("fw3_dout",  32'(f_dout),  32'(9'h0A1 + i));
      check("fw3_valid", 32'(f_valid), 32'h1);
      check("fw3_cnt",   32'(f_cnt),   32'(3 - i));
    end
    step();
    f_rd = 0;
    check("fw3_last_valid", 32'(f_valid), 32'h0);
    check("fw3_last_cnt",   32'(f_cnt),   32'h0);

    // Reset while holding ten words: immediate reset state, no stale data.
    for (int i = 0; i < 10; i++) begin
      s_wr = 1; s_din = W'(9'h050 + i);
      step();
    end
    s_wr = 0;
    check("mid_cnt", 32'(s_cnt), 32'd10);
    #2;
    ResetN = 1'b0;
    #1;
    chk_rst();
    step(); step();
    ResetN = 1'b1;
    step(); step(); step();
    s_wr = 1; s_din = 9'h1AB;
    step();
    s_wr = 0;
    check("post_k_empty",  32'(s_empty), 32'h1);
    check("post_k_cnt",    32'(s_cnt),   32'd1);
    step();
    check("post_k1_empty", 32'(s_empty), 32'h0);
    check("post_nostale",  32'(s_dout),  32'h0);
    s_rd = 1;
    step();
    s_rd = 0;
    check("post_dout",  32'(s_dout),  32'h1AB);
    check("post_valid", 32'(s_valid), 32'h1);
    check("post_cnt",   32'(s_cnt),   32'h0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
